// File: rtl/mips_instr_encoder.sv
// Packs instruction requests into 32-bit MIPS words and streams them into the
// instruction-memory load port; the li pseudo-op expands into lui+ori.
module mips_instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_EMIT2 = 1'b1;

    localparam logic [3:0] K_ADDU = 4'd0;
    localparam logic [3:0] K_SUBU = 4'd1;
    localparam logic [3:0] K_OR   = 4'd2;
    localparam logic [3:0] K_ORI  = 4'd3;
    localparam logic [3:0] K_LUI  = 4'd4;
    localparam logic [3:0] K_LW   = 4'd5;
    localparam logic [3:0] K_SW   = 4'd6;
    localparam logic [3:0] K_SB   = 4'd7;
    localparam logic [3:0] K_BEQ  = 4'd8;
    localparam logic [3:0] K_J    = 4'd9;
    localparam logic [3:0] K_JAL  = 4'd10;
    localparam logic [3:0] K_JR   = 4'd11;
    localparam logic [3:0] K_NOP  = 4'd12;
    localparam logic [3:0] K_LI   = 4'd13;

    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST  = DEPTH - ONE;

    logic [0:0]      state_q, state_d;
    logic            im_we_q, im_we_d;
    logic [31:0]     im_addr_q, im_addr_d;
    logic [31:0]     im_wdata_q, im_wdata_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            full_q, full_d;
    logic            err_q, err_d;
    logic [4:0]      li_rt_q, li_rt_d;
    logic [15:0]     li_lo_q, li_lo_d;

    logic            accept;
    logic            legal;
    logic [31:0]     word;
    logic [31:0]     wr_addr;
    logic [ADDR_W:0] count_inc;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

    always_comb begin
        legal = 1'b1;
        word  = 32'h0;
        case (in_kind)
            K_ADDU:  word = r_type(in_rs, in_rt, in_rd, 6'h21);
            K_SUBU:  word = r_type(in_rs, in_rt, in_rd, 6'h23);
            K_OR:    word = r_type(in_rs, in_rt, in_rd, 6'h25);
            K_ORI:   word = i_type(OP_ORI, in_rs, in_rt, in_imm[15:0]);
            K_LUI:   word = i_type(OP_LUI, 5'h00, in_rt, in_imm[15:0]);
            K_LW:    word = i_type(6'h23, in_rs, in_rt, in_imm[15:0]);
            K_SW:    word = i_type(6'h2B, in_rs, in_rt, in_imm[15:0]);
            K_SB:    word = i_type(6'h28, in_rs, in_rt, in_imm[15:0]);
            K_BEQ:   word = i_type(6'h04, in_rs, in_rt, in_imm[15:0]);
            K_J:     word = {6'h02, in_imm[27:2]};
            K_JAL:   word = {6'h03, in_imm[27:2]};
            K_JR:    word = {6'h00, in_rs, 15'h0000, 6'h08};
            K_NOP:   word = 32'h0;
            // First half of li; the ori half is produced from li_*_q in EMIT2.
            K_LI:    word = i_type(OP_LUI, 5'h00, in_rt, in_imm[31:16]);
            default: legal = 1'b0;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) & ~full_q & ~restart;
    assign accept    = in_valid & in_ready;
    assign wr_addr   = BASE_ADDR + 32'({count_q, 2'b00});
    assign count_inc = count_q + ONE;

    always_comb begin
        state_d    = state_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        count_d    = count_q;
        full_d     = full_q;
        err_d      = 1'b0;
        li_rt_d    = li_rt_q;
        li_lo_d    = li_lo_q;

        if (restart) begin
            state_d   = ST_IDLE;
            im_addr_d = BASE_ADDR;
            count_d   = '0;
            full_d    = 1'b0;
        end else if (state_q == ST_EMIT2) begin
            state_d    = ST_IDLE;
            im_we_d    = 1'b1;
            im_addr_d  = wr_addr;
            im_wdata_d = i_type(OP_ORI, li_rt_q, li_rt_q, li_lo_q);
            count_d    = count_inc;
            full_d     = (count_inc == DEPTH);
        end else if (accept) begin
            // li is atomic: with only one slot left neither half is written.
            if (!legal || (in_kind == K_LI && count_q == LAST)) begin
                err_d = 1'b1;
            end else begin
                im_we_d    = 1'b1;
                im_addr_d  = wr_addr;
                im_wdata_d = word;
                count_d    = count_inc;
                full_d     = (count_inc == DEPTH);
                if (in_kind == K_LI) begin
                    state_d = ST_EMIT2;
                    li_rt_d = in_rt;
                    li_lo_d = in_imm[15:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            im_we_q    <= 1'b0;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= 32'h0;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            li_rt_q    <= 5'h00;
            li_lo_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            count_q    <= count_d;
            full_q     <= full_d;
            err_q      <= err_d;
            li_rt_q    <= li_rt_d;
            li_lo_q    <= li_lo_d;
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign count    = count_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule
